// File: rtl/acq_pkg.sv
// Shared types and sizes for the hydrophone capture sequencer.
package acq_pkg;

    localparam int NCHAN       = 4;
    localparam int FRAME_CNT_W = 16;
    localparam int TMR_W       = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_ALL = 3'd1,
        ST_ALIGN    = 3'd2,
        ST_SETTLE   = 3'd3,
        ST_READY    = 3'd4,
        ST_RELEASE  = 3'd5
    } seq_state_e;

    // A frame is coherent only when every channel filled the same bank.
    function automatic logic banks_agree(input logic [NCHAN-1:0] bank);
        return (&bank) | ~(|bank);
    endfunction

endpackage

// File: rtl/capture_seq_ctrl_if.sv
// Channel-buffer / register-block signal bundle seen by the capture sequencer.
interface capture_seq_ctrl_if;

    logic                               I_softReset;
    logic                               I_enable;
    logic [acq_pkg::NCHAN-1:0]          I_chanRdy;
    logic [acq_pkg::NCHAN-1:0]          I_chanBank;
    logic                               I_dataRead;
    logic                               I_errClr;
    logic                               O_sampleRdy;
    logic                               O_bankSelect;
    logic                               O_chanRelease;
    logic                               O_overrun;
    logic                               O_skewErr;
    logic [acq_pkg::FRAME_CNT_W-1:0]    O_frameCount;
    logic [2:0]                         O_state;

    modport master (
        input  I_softReset, I_enable, I_chanRdy, I_chanBank, I_dataRead, I_errClr,
        output O_sampleRdy, O_bankSelect, O_chanRelease, O_overrun, O_skewErr,
               O_frameCount, O_state
    );

    modport slave (
        output I_softReset, I_enable, I_chanRdy, I_chanBank, I_dataRead, I_errClr,
        input  O_sampleRdy, O_bankSelect, O_chanRelease, O_overrun, O_skewErr,
               O_frameCount, O_state
    );

endinterface

// File: rtl/seq_timer.sv
// Loadable 8-bit down-counter, shared between skew and settle timing.
module seq_timer
    import acq_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [TMR_W-1:0] i_loadVal,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [TMR_W-1:0] r_cnt;

    // Holds at zero so a late reader still sees the expiry.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_loadVal;
        else if (i_dec && (r_cnt != '0))
            r_cnt <= r_cnt - TMR_W'(1);
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/capture_seq_ctrl.sv
// Frame sequencer: waits for aligned, settled channel buffers, presents one frame
// to the register block and releases the buffers once the DSP has read it.
module capture_seq_ctrl #(
    parameter int SETTLE_CYCLES = 7,
    parameter int SKEW_LIMIT    = 15,
    parameter int NCHAN         = acq_pkg::NCHAN
) (
    input  logic               BF_I_clk,
    input  logic               I_rst_n,
    capture_seq_ctrl_if.master bus
);
    import acq_pkg::*;

    // Timer counts down to zero; expiry lands on the N-th edge after entry.
    localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] SKEW_LD   = TMR_W'(SKEW_LIMIT - 1);

    seq_state_e             r_state;
    logic                   r_sampleRdy;
    logic                   r_bankSelect;
    logic                   r_chanRelease;
    logic                   r_overrun;
    logic                   r_skewErr;
    logic [FRAME_CNT_W-1:0] r_frameCount;

    logic             w_allRdy;
    logic             w_anyRdy;
    logic             w_bankDiff;
    logic             w_toAlign;
    logic             w_toSettle;
    logic             w_tmrLoad;
    logic             w_tmrDec;
    logic             w_tmrZero;
    logic [TMR_W-1:0] w_tmrLdVal;

    assign w_allRdy   = &bus.I_chanRdy;
    assign w_anyRdy   = |bus.I_chanRdy;
    assign w_bankDiff = (bus.I_chanBank != {NCHAN{r_bankSelect}});

    // Entry conditions are shared by the FSM and the timer so both agree on the edge.
    assign w_toAlign  = bus.I_enable &&
                        (((r_state == ST_WAIT_ALL) && w_anyRdy && !w_allRdy) ||
                         ((r_state == ST_SETTLE) && !w_allRdy));
    assign w_toSettle = bus.I_enable && w_allRdy &&
                        ((r_state == ST_WAIT_ALL) || (r_state == ST_ALIGN));
    assign w_tmrLoad  = w_toAlign | w_toSettle;
    assign w_tmrLdVal = w_toSettle ? SETTLE_LD : SKEW_LD;
    assign w_tmrDec   = (r_state == ST_ALIGN) || (r_state == ST_SETTLE);

    seq_timer u_timer (
        .i_clk     (BF_I_clk),
        .i_rst_n   (I_rst_n),
        .i_clr     (bus.I_softReset),
        .i_load    (w_tmrLoad),
        .i_loadVal (w_tmrLdVal),
        .i_dec     (w_tmrDec),
        .o_zero    (w_tmrZero)
    );

    always_ff @(posedge BF_I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_state       <= ST_IDLE;
            r_sampleRdy   <= 1'b0;
            r_bankSelect  <= 1'b0;
            r_chanRelease <= 1'b0;
            r_overrun     <= 1'b0;
            r_skewErr     <= 1'b0;
            r_frameCount  <= '0;
        end else if (bus.I_softReset) begin
            r_state       <= ST_IDLE;
            r_sampleRdy   <= 1'b0;
            r_bankSelect  <= 1'b0;
            r_chanRelease <= 1'b0;
            r_overrun     <= 1'b0;
            r_skewErr     <= 1'b0;
            r_frameCount  <= '0;
        end else begin
            r_chanRelease <= 1'b0;
            // Clear first so a same-cycle error set below takes precedence.
            if (bus.I_errClr) begin
                r_overrun <= 1'b0;
                r_skewErr <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (bus.I_enable)
                        r_state <= ST_WAIT_ALL;
                end
                ST_WAIT_ALL: begin
                    if (!bus.I_enable)
                        r_state <= ST_IDLE;
                    else if (w_toSettle)
                        r_state <= ST_SETTLE;
                    else if (w_toAlign)
                        r_state <= ST_ALIGN;
                end
                ST_ALIGN: begin
                    if (!bus.I_enable)
                        r_state <= ST_IDLE;
                    else if (w_toSettle)
                        r_state <= ST_SETTLE;
                    else if (w_tmrZero) begin
                        r_skewErr     <= 1'b1;
                        r_chanRelease <= 1'b1;
                        r_state       <= ST_RELEASE;
                    end
                end
                ST_SETTLE: begin
                    if (!bus.I_enable)
                        r_state <= ST_IDLE;
                    else if (w_toAlign)
                        r_state <= ST_ALIGN;
                    else if (w_tmrZero) begin
                        if (banks_agree(bus.I_chanBank)) begin
                            r_bankSelect <= bus.I_chanBank[0];
                            r_frameCount <= r_frameCount + FRAME_CNT_W'(1);
                            r_sampleRdy  <= 1'b1;
                            r_state      <= ST_READY;
                        end else begin
                            r_skewErr     <= 1'b1;
                            r_chanRelease <= 1'b1;
                            r_state       <= ST_RELEASE;
                        end
                    end
                end
                ST_READY: begin
                    // A channel moving on to another bank while the frame is held is an overrun.
                    if (w_bankDiff)
                        r_overrun <= 1'b1;
                    if (bus.I_dataRead) begin
                        r_sampleRdy   <= 1'b0;
                        r_chanRelease <= 1'b1;
                        r_state       <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (!w_anyRdy)
                        r_state <= bus.I_enable ? ST_WAIT_ALL : ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.O_sampleRdy   = r_sampleRdy;
    assign bus.O_bankSelect  = r_bankSelect;
    assign bus.O_chanRelease = r_chanRelease;
    assign bus.O_overrun     = r_overrun;
    assign bus.O_skewErr     = r_skewErr;
    assign bus.O_frameCount  = r_frameCount;
    assign bus.O_state       = r_state;

endmodule

// File: tb/tb_capture_seq_ctrl.sv
// Directed bench for capture_seq_ctrl: a per-cycle vector table for one full frame,
// then hand-written sequences for skew, bank disagreement, overrun, reset and wrap.
module tb_capture_seq_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    capture_seq_ctrl_if bus();

    capture_seq_ctrl #(
        .SETTLE_CYCLES (7),
        .SKEW_LIMIT    (15),
        .NCHAN         (4)
    ) dut (
        .BF_I_clk (clk),
        .I_rst_n  (rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [3:0]  rdy;
        logic [3:0]  bank;
        logic        rd;
        logic        clr;
        logic [2:0]  st;
        logic        srdy;
        logic        bsel;
        logic        rel;
        logic        skew;
        logic        ovr;
        logic [15:0] fcnt;
    } vec_t;

    vec_t vecs[13];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic [3:0] rdy, input logic [3:0] bank,
                         input logic rd, input logic clr);
        bus.I_enable   = en;
        bus.I_chanRdy  = rdy;
        bus.I_chanBank = bank;
        bus.I_dataRead = rd;
        bus.I_errClr   = clr;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [2:0] st, input logic srdy,
                           input logic bsel, input logic rel, input logic skew,
                           input logic ovr, input logic [15:0] fcnt);
        chk({tag, ".state"},   16'(bus.O_state),       16'(st));
        chk({tag, ".srdy"},    16'(bus.O_sampleRdy),   16'(srdy));
        chk({tag, ".bsel"},    16'(bus.O_bankSelect),  16'(bsel));
        chk({tag, ".release"}, 16'(bus.O_chanRelease), 16'(rel));
        chk({tag, ".skew"},    16'(bus.O_skewErr),     16'(skew));
        chk({tag, ".overrun"}, 16'(bus.O_overrun),     16'(ovr));
        chk({tag, ".fcnt"},    bus.O_frameCount,       fcnt);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.I_softReset = 1'b0;
        drive(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        rst_n = 1'b1;
        tick;
        chk_all("idle", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);

        // Full frame, banks 1111: ready sampled at v1, frame presented seven edges later.
        //          en    rdy   bank  rd    clr   st    srdy  bsel  rel   skew  ovr   fcnt
        vecs[0]  = '{1'b1, 4'h0, 4'hF, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
        vecs[1]  = '{1'b1, 4'hF, 4'hF, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
        for (int i = 2; i < 8; i++) vecs[i] = vecs[1];
        vecs[8]  = '{1'b1, 4'hF, 4'hF, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1};
        vecs[9]  = vecs[8];
        vecs[10] = '{1'b1, 4'hF, 4'hF, 1'b1, 1'b0, 3'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd1};
        vecs[11] = '{1'b1, 4'hF, 4'hF, 1'b0, 1'b0, 3'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1};
        vecs[12] = '{1'b1, 4'h0, 4'hF, 1'b0, 1'b0, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1};
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].en, vecs[i].rdy, vecs[i].bank, vecs[i].rd, vecs[i].clr);
            tick;
            chk_all($sformatf("frame.v%0d", i), vecs[i].st, vecs[i].srdy, vecs[i].bsel,
                    vecs[i].rel, vecs[i].skew, vecs[i].ovr, vecs[i].fcnt);
        end

        // Skew timeout: chan A first, B/C later, D never.
        drive(1'b1, 4'b0001, 4'hF, 1'b0, 1'b0);
        tick;
        chk_all("skew.K", 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1);
        for (int i = 1; i < 15; i++) begin
            if (i == 7) bus.I_chanRdy = 4'b0111;
            tick;
            chk_all($sformatf("skew.K+%0d", i), 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1);
        end
        tick;
        chk_all("skew.K+15", 3'd5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'd1);
        tick;
        chk_all("skew.hold", 3'd5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd1);
        drive(1'b1, 4'h0, 4'hF, 1'b0, 1'b0);
        tick;
        chk_all("skew.wait", 3'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd1);
        drive(1'b1, 4'h0, 4'hF, 1'b0, 1'b1);
        tick;
        chk_all("skew.clr", 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1);

        // Bank disagreement at end of settle: error, no frame.
        drive(1'b1, 4'hF, 4'b1101, 1'b0, 1'b0);
        tick;
        chk_all("bank.N", 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1);
        for (int i = 1; i < 7; i++) begin
            tick;
            chk_all($sformatf("bank.N+%0d", i), 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1);
        end
        tick;
        chk_all("bank.N+7", 3'd5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'd1);
        drive(1'b1, 4'h0, 4'b1101, 1'b0, 1'b1);
        tick;
        chk_all("bank.clr", 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1);

        // Overrun: frame on bank 0, channels move on to bank 1 while held.
        drive(1'b1, 4'hF, 4'h0, 1'b0, 1'b0);
        repeat (8) tick;
        chk_all("ovr.ready", 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2);
        bus.I_chanBank = 4'hF;
        tick;
        chk_all("ovr.set", 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd2);
        bus.I_dataRead = 1'b1;
        tick;
        chk_all("ovr.read", 3'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd2);
        drive(1'b1, 4'h0, 4'h0, 1'b0, 1'b0);
        tick;
        chk_all("ovr.sticky", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd2);

        // Skew timeout with errClr held throughout: clear works, but set wins on the error edge.
        drive(1'b1, 4'b1000, 4'h0, 1'b0, 1'b1);
        tick;
        chk_all("skewclr.K", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2);
        for (int i = 1; i < 15; i++) begin
            tick;
            chk_all($sformatf("skewclr.K+%0d", i), 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2);
        end
        tick;
        chk_all("skewclr.K+15", 3'd5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd2);
        drive(1'b1, 4'h0, 4'h0, 1'b0, 1'b0);
        tick;
        chk_all("skewclr.wait", 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd2);

        // Ready drop during settle returns to ALIGN; enable low abandons to IDLE.
        drive(1'b1, 4'hF, 4'hF, 1'b0, 1'b0);
        tick;
        chk_all("drop.settle", 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd2);
        bus.I_chanRdy = 4'b0111;
        tick;
        chk_all("drop.align", 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd2);
        bus.I_enable = 1'b0;
        tick;
        chk_all("drop.idle", 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd2);

        // Async reset in the middle of SETTLE.
        drive(1'b1, 4'hF, 4'hF, 1'b0, 1'b0);
        tick;
        chk_all("rst.wait", 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd2);
        repeat (3) tick;
        chk_all("rst.settle", 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd2);
        #3;
        rst_n = 1'b0;
        #1;
        chk_all("rst.async", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        @(posedge clk);
        #1;
        chk_all("rst.held", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        rst_n = 1'b1;
        drive(1'b1, 4'h0, 4'h0, 1'b0, 1'b0);
        tick;
        chk_all("rst.rearm", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        bus.I_softReset = 1'b1;
        tick;
        chk_all("soft.reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        bus.I_softReset = 1'b0;
        tick;
        chk_all("soft.rearm", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);

        // Frame counter wrap from FFFF.
        force dut.r_frameCount = 16'hFFFF;
        tick;
        release dut.r_frameCount;
        drive(1'b1, 4'hF, 4'hF, 1'b0, 1'b0);
        repeat (8) tick;
        chk_all("wrap.ready", 3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
        bus.I_dataRead = 1'b1;
        tick;
        chk_all("wrap.read", 3'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
        drive(1'b1, 4'h0, 4'hF, 1'b0, 1'b0);
        tick;
        chk_all("wrap.wait", 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
